// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the MIPS pipeline.
// It captures the decoded ID fields and register-file operands, and it bypasses
// any same-cycle writeback into the captured operands. It forwards EX/MEM and
// MEM/WB results onto the execute operands. It also detects load-use hazards,
// inserts a single bubble for each one, and stalls upstream while it does so.
//
// Flow-control contract:
//   id_valid qualifies the ID slot. The stage accepts the ID instruction on an
//   edge only when stall_out is low on that edge.
//   ex_stall is a hold request from downstream. While it is high, every register
//   in this stage keeps its value and stall_out is high.
//   A flush on an edge without ex_stall squashes the ID instruction and loads a
//   bubble. Because the instruction is discarded, a flush also masks the
//   load-use stall.
module id_ex_stage #(
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  // decode slot
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_dest,
  input  logic [31:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       s1val,
  input  logic [31:0]       s2val,
  // EX/MEM register contents
  input  logic [4:0]        mem_dest,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic [31:0]       mem_result,
  // MEM/WB register contents (also the register-file write port)
  input  logic [4:0]        wb_dest,
  input  logic              wb_reg_write,
  input  logic [31:0]       wb_result,
  // control
  input  logic              flush,
  input  logic              ex_stall,
  // execute-side outputs
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_dest,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [31:0]       ex_opa,
  output logic [31:0]       ex_opb,
  output logic              stall_out,
  output logic [CNT_W-1:0]  lu_bubbles
);

  // Control bundle bit positions
  localparam int CTRL_REG_WRITE = 0;
  localparam int CTRL_MEM_READ  = 1;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // ID/EX register state
  logic              ex_valid_q,   ex_valid_d;
  logic [31:0]       ex_pc_q,      ex_pc_d;
  logic [31:0]       ex_imm_q,     ex_imm_d;
  logic [4:0]        ex_dest_q,    ex_dest_d;
  logic [CTRL_W-1:0] ex_ctrl_q,    ex_ctrl_d;
  logic [4:0]        ex_rs_q,      ex_rs_d;
  logic [4:0]        ex_rt_q,      ex_rt_d;
  logic [31:0]       raw_a_q,      raw_a_d;
  logic [31:0]       raw_b_q,      raw_b_d;
  logic [CNT_W-1:0]  lu_bubbles_q, lu_bubbles_d;

  // Hazard and bypass decisions
  logic        load_use;
  logic        ex_is_load;
  logic        byp_a;
  logic        byp_b;
  logic [31:0] cap_a;
  logic [31:0] cap_b;
  logic        fwd_mem_ok;
  logic        fwd_wb_ok;

  // Load-use detection. The instruction in EX is a load whose result is
  // needed by the instruction in ID. Register 0 never creates a dependency.
  always_comb begin
    ex_is_load = ex_valid_q & ex_ctrl_q[CTRL_MEM_READ] & (ex_dest_q != 5'd0);
    load_use   = ex_is_load & id_valid &
                 ((ex_dest_q == id_rs) | (ex_dest_q == id_rt));
    stall_out  = ex_stall | (load_use & ~flush);
  end

  // Capture bypass. The register-file read was launched on the previous edge,
  // so a write that lands this cycle is not yet reflected in s1val/s2val.
  always_comb begin
    byp_a = wb_reg_write & (wb_dest != 5'd0) & (wb_dest == id_rs);
    byp_b = wb_reg_write & (wb_dest != 5'd0) & (wb_dest == id_rt);
    cap_a = byp_a ? wb_result : s1val;
    cap_b = byp_b ? wb_result : s2val;
  end

  // Next-state selection: hold, bubble or capture, in priority order.
  // The bubble counter advances only when a load-use bubble is actually inserted.
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_pc_d      = ex_pc_q;
    ex_imm_d     = ex_imm_q;
    ex_dest_d    = ex_dest_q;
    ex_ctrl_d    = ex_ctrl_q;
    ex_rs_d      = ex_rs_q;
    ex_rt_d      = ex_rt_q;
    raw_a_d      = raw_a_q;
    raw_b_d      = raw_b_q;
    lu_bubbles_d = lu_bubbles_q;

    if (ex_stall) begin
      // hold everything; any pending hazard is re-evaluated after release
    end else if (flush || load_use || !id_valid) begin
      ex_valid_d = 1'b0;
      ex_pc_d    = '0;
      ex_imm_d   = '0;
      ex_dest_d  = '0;
      ex_ctrl_d  = '0;
      ex_rs_d    = '0;
      ex_rt_d    = '0;
      raw_a_d    = '0;
      raw_b_d    = '0;
      if (!flush && load_use && (lu_bubbles_q != CNT_MAX)) begin
        lu_bubbles_d = lu_bubbles_q + 1'b1;
      end
    end else begin
      ex_valid_d = 1'b1;
      ex_pc_d    = id_pc;
      ex_imm_d   = id_imm;
      ex_dest_d  = id_dest;
      ex_ctrl_d  = id_ctrl;
      ex_rs_d    = id_rs;
      ex_rt_d    = id_rt;
      raw_a_d    = cap_a;
      raw_b_d    = cap_b;
    end
  end

  // ID/EX register with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_imm_q     <= '0;
      ex_dest_q    <= '0;
      ex_ctrl_q    <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      raw_a_q      <= '0;
      raw_b_q      <= '0;
      lu_bubbles_q <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_imm_q     <= ex_imm_d;
      ex_dest_q    <= ex_dest_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      raw_a_q      <= raw_a_d;
      raw_b_q      <= raw_b_d;
      lu_bubbles_q <= lu_bubbles_d;
    end
  end

  // Execute forwarding. MEM beats WB because it is the younger result.
  // Loads in MEM carry an address rather than data, so they are never forwarded.
  always_comb begin
    fwd_mem_ok = mem_reg_write & ~mem_mem_read & (mem_dest != 5'd0);
    fwd_wb_ok  = wb_reg_write & (wb_dest != 5'd0);

    if (fwd_mem_ok && (mem_dest == ex_rs_q)) begin
      ex_opa = mem_result;
    end else if (fwd_wb_ok && (wb_dest == ex_rs_q)) begin
      ex_opa = wb_result;
    end else begin
      ex_opa = raw_a_q;
    end

    if (fwd_mem_ok && (mem_dest == ex_rt_q)) begin
      ex_opb = mem_result;
    end else if (fwd_wb_ok && (wb_dest == ex_rt_q)) begin
      ex_opb = wb_result;
    end else begin
      ex_opb = raw_b_q;
    end
  end

  // Registered outputs
  always_comb begin
    ex_valid   = ex_valid_q;
    ex_pc      = ex_pc_q;
    ex_imm     = ex_imm_q;
    ex_dest    = ex_dest_q;
    ex_ctrl    = ex_ctrl_q;
    ex_rs      = ex_rs_q;
    ex_rt      = ex_rt_q;
    lu_bubbles = lu_bubbles_q;
  end

  // The reg_write bit is part of the opaque pass-through bundle; it is named
  // here only to document the encoding used by downstream stages.
  logic ctrl_reg_write_unused;
  assign ctrl_reg_write_unused = ex_ctrl_q[CTRL_REG_WRITE];

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and random checks of id_ex_stage against a
// behavioural model of the EX slot contents and the bubble count.
module tb_id_ex_stage;

  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              reset;
  logic              id_valid;
  logic [31:0]       id_pc;
  logic [4:0]        id_rs, id_rt, id_dest;
  logic [31:0]       id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic [31:0]       s1val, s2val;
  logic [4:0]        mem_dest;
  logic              mem_reg_write, mem_mem_read;
  logic [31:0]       mem_result;
  logic [4:0]        wb_dest;
  logic              wb_reg_write;
  logic [31:0]       wb_result;
  logic              flush, ex_stall;
  logic              ex_valid;
  logic [31:0]       ex_pc, ex_imm;
  logic [4:0]        ex_dest;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [4:0]        ex_rs, ex_rt;
  logic [31:0]       ex_opa, ex_opb;
  logic              stall_out;
  logic [CNT_W-1:0]  lu_bubbles;

  id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt),
    .id_dest(id_dest), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .s1val(s1val), .s2val(s2val),
    .mem_dest(mem_dest), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_result(mem_result),
    .wb_dest(wb_dest), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .flush(flush), .ex_stall(ex_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_dest(ex_dest),
    .ex_ctrl(ex_ctrl), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_opa(ex_opa), .ex_opb(ex_opb),
    .stall_out(stall_out), .lu_bubbles(lu_bubbles)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the instruction sitting in EX (or an empty slot)
  typedef struct {
    bit          valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic [7:0]  ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] a;
    logic [31:0] b;
  } slot_t;

  slot_t m;
  int    m_cnt;
  int    n_checks;
  int    n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic slot_t empty_slot();
    slot_t s;
    s = '{valid: 1'b0, pc: '0, imm: '0, dest: '0, ctrl: '0, rs: '0, rt: '0, a: '0, b: '0};
    return s;
  endfunction

  // The value a source register holds as seen in EX: the youngest non-load
  // writer in MEM, else the writer in WB, else the captured operand.
  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] raw);
    if (r != 0 && mem_reg_write && !mem_mem_read && mem_dest == r) return mem_result;
    if (r != 0 && wb_reg_write && wb_dest == r) return wb_result;
    return raw;
  endfunction

  // The value a register holds at decode time, counting a same-cycle writeback.
  function automatic logic [31:0] reg_at_decode(input logic [4:0] r, input logic [31:0] rf);
    if (r != 0 && wb_reg_write && wb_dest == r) return wb_result;
    return rf;
  endfunction

  function automatic bit hazard();
    return m.valid && m.ctrl[1] && m.dest != 0 && id_valid &&
           (m.dest == id_rs || m.dest == id_rt);
  endfunction

  task automatic check_all(input string pfx);
    check({pfx, ".valid"}, 32'(ex_valid), 32'(m.valid));
    check({pfx, ".pc"}, ex_pc, m.pc);
    check({pfx, ".imm"}, ex_imm, m.imm);
    check({pfx, ".dest"}, 32'(ex_dest), 32'(m.dest));
    check({pfx, ".ctrl"}, 32'(ex_ctrl), 32'(m.ctrl));
    check({pfx, ".rs"}, 32'(ex_rs), 32'(m.rs));
    check({pfx, ".rt"}, 32'(ex_rt), 32'(m.rt));
    check({pfx, ".opa"}, ex_opa, operand(m.rs, m.a));
    check({pfx, ".opb"}, ex_opb, operand(m.rt, m.b));
    check({pfx, ".stall"}, 32'(stall_out), 32'(ex_stall || (hazard() && !flush)));
    check({pfx, ".lu"}, 32'(lu_bubbles), m_cnt[31:0]);
  endtask

  // Check the current cycle, compute the model's next slot, then clock.
  task automatic step(input string pfx);
    slot_t nm;
    #1;
    check_all(pfx);
    nm = m;
    if (ex_stall) begin
      nm = m;
    end else if (flush) begin
      nm = empty_slot();
    end else if (hazard()) begin
      nm = empty_slot();
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else if (!id_valid) begin
      nm = empty_slot();
    end else begin
      nm = '{valid: 1'b1, pc: id_pc, imm: id_imm, dest: id_dest, ctrl: id_ctrl,
             rs: id_rs, rt: id_rt, a: reg_at_decode(id_rs, s1val),
             b: reg_at_decode(id_rt, s2val)};
    end
    @(posedge clk);
    m = nm;
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_pc = '0; id_rs = '0; id_rt = '0; id_dest = '0;
    id_imm = '0; id_ctrl = '0; s1val = '0; s2val = '0;
    mem_dest = '0; mem_reg_write = 0; mem_mem_read = 0; mem_result = '0;
    wb_dest = '0; wb_reg_write = 0; wb_result = '0;
    flush = 0; ex_stall = 0;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] d,
                        input logic [7:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    id_valid = 1; id_rs = rs; id_rt = rt; id_dest = d; id_ctrl = ctrl;
    s1val = a; s2val = b; id_pc = id_pc + 32'd4; id_imm = $urandom;
  endtask

  task automatic rand_inputs();
    id_valid      = ($urandom_range(0, 5) != 0);
    id_pc         = $urandom;
    id_rs         = 5'($urandom_range(0, 3));
    id_rt         = 5'($urandom_range(0, 3));
    id_dest       = 5'($urandom_range(0, 3));
    id_imm        = $urandom;
    id_ctrl       = 8'($urandom_range(0, 255));
    s1val         = $urandom;
    s2val         = $urandom;
    mem_dest      = 5'($urandom_range(0, 3));
    mem_reg_write = 1'($urandom_range(0, 1));
    mem_mem_read  = ($urandom_range(0, 3) == 0);
    mem_result    = $urandom;
    wb_dest       = 5'($urandom_range(0, 3));
    wb_reg_write  = 1'($urandom_range(0, 1));
    wb_result     = $urandom;
    flush         = ($urandom_range(0, 9) == 0);
    ex_stall      = ($urandom_range(0, 4) == 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m        = empty_slot();
    m_cnt    = 0;
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    // outputs while in reset
    check_all("reset");
    reset = 0;

    // add r3,r1,r2 with plain operands
    set_id(5'd1, 5'd2, 5'd3, 8'h01, 32'd5, 32'd7);
    step("add");
    idle_inputs();
    #1;
    check("tp_add.valid", 32'(ex_valid), 32'd1);
    check("tp_add.opa", ex_opa, 32'd5);
    check("tp_add.opb", ex_opb, 32'd7);
    check("tp_add.dest", 32'(ex_dest), 32'd3);
    check("tp_add.stall", 32'(stall_out), 32'd0);

    // lw r4 followed by a dependent add
    set_id(5'd1, 5'd2, 5'd4, 8'h03, 32'd100, 32'd0);
    step("lw");
    set_id(5'd4, 5'd1, 5'd5, 8'h01, 32'd0, 32'd9);
    #1;
    check("tp_lu.stall", 32'(stall_out), 32'd1);
    step("lu_bubble");
    check("tp_lu.valid", 32'(ex_valid), 32'd0);
    check("tp_lu.count", 32'(lu_bubbles), 32'd1);
    wb_dest = 5'd4; wb_reg_write = 1; wb_result = 32'hDEAD;
    step("lu_capture");
    check("tp_lu.opa", ex_opa, 32'hDEAD);

    // MEM beats WB on the execute operand
    idle_inputs();
    set_id(5'd2, 5'd3, 5'd6, 8'h01, 32'd1, 32'd2);
    step("add6");
    id_valid = 0;
    mem_dest = 5'd2; mem_reg_write = 1; mem_result = 32'd11;
    wb_dest = 5'd2; wb_reg_write = 1; wb_result = 32'd22;
    #1;
    check("tp_fwd.mem", ex_opa, 32'd11);
    mem_reg_write = 0;
    #1;
    check("tp_fwd.wb", ex_opa, 32'd22);

    // register 0 is never forwarded or bypassed
    idle_inputs();
    wb_dest = 5'd0; wb_reg_write = 1; wb_result = 32'hFFFF;
    set_id(5'd0, 5'd0, 5'd7, 8'h01, 32'd0, 32'd0);
    step("r0");
    check("tp_r0.opa", ex_opa, 32'd0);
    check("tp_r0.opb", ex_opb, 32'd0);

    // downstream hold then flush on the release edge
    idle_inputs();
    set_id(5'd1, 5'd2, 5'd8, 8'h05, 32'd3, 32'd4);
    step("pre_hold");
    ex_stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(5'($urandom_range(1, 3)), 5'd2, 5'd9, 8'h01, $urandom, $urandom);
      #1;
      check("tp_hold.stall", 32'(stall_out), 32'd1);
      check("tp_hold.dest", 32'(ex_dest), 32'd8);
      step("hold");
    end
    ex_stall = 0; flush = 1;
    step("flush");
    check("tp_flush.valid", 32'(ex_valid), 32'd0);
    check("tp_flush.ctrl", 32'(ex_ctrl), 32'd0);

    // 18 load-use events saturate the counter
    idle_inputs();
    for (int i = 0; i < 18; i++) begin
      set_id(5'd1, 5'd2, 5'd4, 8'h03, 32'd0, 32'd0);
      step("sat_lw");
      set_id(5'd4, 5'd1, 5'd5, 8'h01, 32'd0, 32'd0);
      step("sat_use");
    end
    check("tp_sat.count", 32'(lu_bubbles), 32'(CNT_MAX));

    // asynchronous reset between edges, with a hazard pending
    set_id(5'd1, 5'd2, 5'd4, 8'h03, 32'd0, 32'd0);
    step("pre_rst");
    set_id(5'd4, 5'd1, 5'd5, 8'h01, 32'd0, 32'd0);
    #1;
    reset = 1;
    #1;
    idle_inputs();
    m = empty_slot();
    m_cnt = 0;
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    reset = 0;

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
